// File: rtl/opcode_sequencer.sv
// Program buffer and in-order issue sequencer for the ALU control stage.
// Opcodes are loaded in IDLE, then replayed one per clock on start.
module opcode_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          load_valid_in,
    input  logic [20:0]   load_data_in,
    output logic          load_ready_out,
    input  logic          start_in,
    input  logic          pause_in,
    input  logic          clear_in,
    output logic [20:0]   opcode_out,
    output logic          en_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [AW:0]   count_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW:0]   count, count_nxt;
    logic          wr_en;
    logic          can_load;
    logic          last_issue;

    logic [20:0]   mem [DEPTH];

    assign count_out  = count;
    assign can_load   = (state == S_IDLE) && (count < DEPTH_C) && !clear_in;
    // pc is one bit narrower than count; compare at count width
    assign last_issue = ({1'b0, pc} == (count - 1'b1));

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        count_nxt      = count;
        wr_en          = 1'b0;
        load_ready_out = 1'b0;
        opcode_out     = '0;
        en_out         = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;

        case (state)
            S_IDLE: begin
                load_ready_out = can_load;
                if (clear_in) begin
                    count_nxt = '0;
                end else begin
                    if (load_valid_in && can_load) begin
                        wr_en     = 1'b1;
                        count_nxt = count + 1'b1;
                    end
                    if (start_in && (count != '0)) begin
                        pc_nxt    = '0;
                        state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                busy_out = 1'b1;
                en_out   = !pause_in;
                if (!pause_in) begin
                    opcode_out = mem[pc];
                    if (last_issue)
                        state_nxt = S_DONE;
                    else
                        pc_nxt = pc + 1'b1;
                end
            end

            S_DONE: begin
                done_out  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            pc    <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
        end
    end

    // Storage is not reset; entries at or above count are never read out
    always_ff @(posedge clk_in) begin
        if (wr_en && !rst_in)
            mem[count[AW-1:0]] <= load_data_in;
    end

endmodule
